// File: rtl/core_inst_decoder.sv
// Registers each 47-bit core instruction word into SRAM controls and strobes, and
// tracks phase, L0 occupancy, execute/psum statistics, acc bursts and sticky protocol errors.
module core_inst_decoder #(
  parameter int L0_DEPTH = 64,
  parameter int CNT_BW   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [46:0]       inst,
  output logic              xmem_cen,
  output logic              xmem_wen,
  output logic [10:0]       xmem_addr,
  output logic              pmem_cen,
  output logic              pmem_wen,
  output logic [10:0]       pmem_addr,
  output logic              wmem_cen,
  output logic              wmem_wen,
  output logic [10:0]       wmem_addr,
  output logic              acc_o,
  output logic              ofifo_rd_o,
  output logic              ififo_wr_o,
  output logic              ififo_rd_o,
  output logic              l0_rd_o,
  output logic              l0_wr_o,
  output logic              execute_o,
  output logic              load_o,
  output logic [2:0]        phase,
  output logic [6:0]        l0_occ,
  output logic [CNT_BW-1:0] exec_cnt,
  output logic [CNT_BW-1:0] psum_wr_cnt,
  output logic [3:0]        acc_len,
  output logic              acc_done,
  output logic [3:0]        err
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WLOAD = 3'd1,
    PH_EXEC  = 3'd2,
    PH_DRAIN = 3'd3,
    PH_ACC   = 3'd4
  } phase_e;

  // Active-low SRAM enables idle high; everything else idles low.
  localparam logic [46:0] DEC_RESET = (47'(1) << 46) | (47'(1) << 45) |
                                      (47'(1) << 32) | (47'(1) << 31) |
                                      (47'(1) << 19) | (47'(1) << 18);
  localparam logic [6:0]        OCC_MAX = 7'(L0_DEPTH);
  localparam logic [CNT_BW-1:0] CNT_MAX = '1;

  logic [46:0]       dec_q;
  phase_e            phase_q, phase_d;
  logic [6:0]        occ_q, occ_d;
  logic [CNT_BW-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_BW-1:0] psum_cnt_q, psum_cnt_d;
  logic [3:0]        burst_q, burst_d;
  logic [3:0]        acc_len_q, acc_len_d;
  logic              acc_done_q, acc_done_d;
  logic [3:0]        err_q, err_d;

  logic load_s, exec_s, l0_wr_s, l0_rd_s, ififo_wr_s, ofifo_rd_s, acc_s, psum_wr_s;
  logic l0_udf_s, l0_ovf_s;

  assign load_s     = inst[0];
  assign exec_s     = inst[1];
  assign l0_wr_s    = inst[2];
  assign l0_rd_s    = inst[3];
  assign ififo_wr_s = inst[5];
  assign ofifo_rd_s = inst[6];
  assign acc_s      = inst[33];
  assign psum_wr_s  = !inst[32] && !inst[31];
  assign l0_udf_s   = l0_rd_s && !l0_wr_s && (occ_q == 7'd0);
  assign l0_ovf_s   = l0_wr_s && !l0_rd_s && (occ_q == OCC_MAX);

  always_comb begin
    phase_d = phase_q;
    if (acc_s) begin
      phase_d = PH_ACC;
    end else if (phase_q == PH_ACC) begin
      phase_d = PH_IDLE;
    end else if ((phase_q == PH_IDLE || phase_q == PH_WLOAD) && exec_s) begin
      phase_d = PH_EXEC;
    end else if (phase_q == PH_IDLE && (load_s || ififo_wr_s)) begin
      phase_d = PH_WLOAD;
    end else if (phase_q == PH_EXEC && !exec_s) begin
      phase_d = ofifo_rd_s ? PH_DRAIN : PH_IDLE;
    end else if (phase_q == PH_DRAIN && !ofifo_rd_s) begin
      phase_d = PH_IDLE;
    end
  end

  // Occupancy moves only when exactly one of write/read is present, clamped to 0..L0_DEPTH.
  always_comb begin
    occ_d = occ_q;
    if (l0_wr_s && !l0_rd_s && occ_q != OCC_MAX) begin
      occ_d = occ_q + 7'd1;
    end else if (l0_rd_s && !l0_wr_s && occ_q != 7'd0) begin
      occ_d = occ_q - 7'd1;
    end
  end

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    psum_cnt_d = psum_cnt_q;
    if (exec_s && exec_cnt_q != CNT_MAX) begin
      exec_cnt_d = exec_cnt_q + CNT_BW'(1);
    end
    if (psum_wr_s && psum_cnt_q != CNT_MAX) begin
      psum_cnt_d = psum_cnt_q + CNT_BW'(1);
    end
  end

  // A non-zero burst count means the previous word was part of an acc burst.
  always_comb begin
    burst_d    = burst_q;
    acc_len_d  = acc_len_q;
    acc_done_d = 1'b0;
    if (acc_s) begin
      if (burst_q != 4'hF) begin
        burst_d = burst_q + 4'd1;
      end
    end else if (burst_q != 4'd0) begin
      acc_len_d  = burst_q;
      acc_done_d = 1'b1;
      burst_d    = 4'd0;
    end
  end

  always_comb begin
    err_d = err_q | {l0_udf_s || l0_ovf_s,
                     acc_s && psum_wr_s,
                     psum_wr_s && !ofifo_rd_s,
                     load_s && exec_s};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q      <= DEC_RESET;
      phase_q    <= PH_IDLE;
      occ_q      <= 7'd0;
      exec_cnt_q <= '0;
      psum_cnt_q <= '0;
      burst_q    <= 4'd0;
      acc_len_q  <= 4'd0;
      acc_done_q <= 1'b0;
      err_q      <= 4'd0;
    end else begin
      dec_q      <= inst;
      phase_q    <= phase_d;
      occ_q      <= occ_d;
      exec_cnt_q <= exec_cnt_d;
      psum_cnt_q <= psum_cnt_d;
      burst_q    <= burst_d;
      acc_len_q  <= acc_len_d;
      acc_done_q <= acc_done_d;
      err_q      <= err_d;
    end
  end

  assign xmem_cen    = dec_q[46];
  assign xmem_wen    = dec_q[45];
  assign xmem_addr   = dec_q[44:34];
  assign acc_o       = dec_q[33];
  assign pmem_cen    = dec_q[32];
  assign pmem_wen    = dec_q[31];
  assign pmem_addr   = dec_q[30:20];
  assign wmem_cen    = dec_q[19];
  assign wmem_wen    = dec_q[18];
  assign wmem_addr   = dec_q[17:7];
  assign ofifo_rd_o  = dec_q[6];
  assign ififo_wr_o  = dec_q[5];
  assign ififo_rd_o  = dec_q[4];
  assign l0_rd_o     = dec_q[3];
  assign l0_wr_o     = dec_q[2];
  assign execute_o   = dec_q[1];
  assign load_o      = dec_q[0];
  assign phase       = phase_q;
  assign l0_occ      = occ_q;
  assign exec_cnt    = exec_cnt_q;
  assign psum_wr_cnt = psum_cnt_q;
  assign acc_len     = acc_len_q;
  assign acc_done    = acc_done_q;
  assign err         = err_q;

endmodule
